// File: rtl/load_store_unit_pkg.sv
// Shared constants, funct3 width codes and FSM encoding for the load/store unit.
package load_store_unit_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned OFFW = 3;

  typedef enum logic [2:0] {
    F3_B   = 3'b000,
    F3_H   = 3'b001,
    F3_W   = 3'b010,
    F3_D   = 3'b011,
    F3_BU  = 3'b100,
    F3_HU  = 3'b101,
    F3_WU  = 3'b110,
    F3_BAD = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Byte-offset bits that must be zero for a naturally aligned access
  function automatic logic [OFFW-1:0] align_mask(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a load lane from a memory word,
// and merges the addressed store bytes into a memory word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [OFFW-1:0] i_offset,
  input  logic [XLEN-1:0] i_mem_word,
  input  logic [XLEN-1:0] i_store_data,
  output logic [XLEN-1:0] o_load_c,
  output logic [XLEN-1:0] o_merged_c
);

  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_size_mask;
  logic [XLEN-1:0] w_lane_mask;

  assign w_shamt     = {i_offset, 3'b000};
  assign w_lane      = i_mem_word >> w_shamt;
  assign w_lane_mask = w_size_mask << w_shamt;
  assign o_merged_c  = (i_mem_word & ~w_lane_mask) | ((i_store_data << w_shamt) & w_lane_mask);

  always_comb begin
    w_size_mask = '1;
    case (i_funct3[1:0])
      2'd0:    w_size_mask = 64'h0000_0000_0000_00FF;
      2'd1:    w_size_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    w_size_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_size_mask = '1;
    endcase
  end

  // Sign- or zero-extend the selected lane
  always_comb begin
    o_load_c = '0;
    case (i_funct3)
      F3_B:    o_load_c = {{56{w_lane[7]}},  w_lane[7:0]};
      F3_H:    o_load_c = {{48{w_lane[15]}}, w_lane[15:0]};
      F3_W:    o_load_c = {{32{w_lane[31]}}, w_lane[31:0]};
      F3_D:    o_load_c = w_lane;
      F3_BU:   o_load_c = {56'd0, w_lane[7:0]};
      F3_HU:   o_load_c = {48'd0, w_lane[15:0]};
      F3_WU:   o_load_c = {32'd0, w_lane[31:0]};
      default: o_load_c = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV64 load/store unit driving a single-port word-addressed data memory.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them down.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  state_e          r_state;
  state_e          w_next;
  logic [XLEN-1:0] r_word_idx;
  logic [OFFW-1:0] r_offset;
  logic [2:0]      r_funct3;
  logic            r_write;
  logic            r_err;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_mem_wdata;

  logic            w_accept;
  logic [OFFW-1:0] w_mask;
  logic [OFFW-1:0] w_aligned_off;
  logic [XLEN-1:0] w_req_idx;
  logic            w_bad_idx;
  logic            w_bad_f3;
  logic            w_req_err;
  logic [XLEN-1:0] w_load;
  logic [XLEN-1:0] w_merged;

  assign w_accept      = req_valid && (r_state == ST_IDLE);
  assign w_mask        = align_mask(req_funct3);
  assign w_aligned_off = req_addr[OFFW-1:0] & ~w_mask;
  assign w_req_idx     = {3'b000, req_addr[XLEN-1:OFFW]};
  assign w_bad_idx     = (w_req_idx >= 64'(MEM_DEPTH));
  assign w_bad_f3      = (req_funct3 == F3_BAD) || (req_write && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = |(req_addr[OFFW-1:0] & w_mask);
  assign w_req_err    = w_bad_f3 || w_bad_idx || w_misaligned;
`else
  assign w_req_err    = w_bad_f3 || w_bad_idx;
`endif

  lsu_lane_align u_lane_align (
    .i_funct3     (r_funct3),
    .i_offset     (r_offset),
    .i_mem_word   (mem_read_data),
    .i_store_data (r_mem_wdata),
    .o_load_c     (w_load),
    .o_merged_c   (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_req_err)                             w_next = ST_RESP;
          else if (req_write && req_funct3 == F3_D)  w_next = ST_WRITE;
          else                                       w_next = ST_READ;
        end
      end
      ST_READ:  w_next = r_write ? ST_WRITE : ST_RESP;
      ST_WRITE: w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Strobes and handshakes decode directly from the state register
  always_comb begin
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      ST_IDLE:  req_ready  = 1'b1;
      ST_READ:  mem_read   = 1'b1;
      ST_WRITE: mem_write  = 1'b1;
      ST_RESP:  resp_valid = 1'b1;
      default:  req_ready  = 1'b0;
    endcase
  end

  // Request capture; READ either loads the result or pre-merges partial store data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_idx  <= '0;
      r_offset    <= '0;
      r_funct3    <= '0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_wdata <= '0;
    end else if (w_accept) begin
      r_word_idx  <= w_req_idx;
      r_offset    <= w_aligned_off;
      r_funct3    <= req_funct3;
      r_write     <= req_write;
      r_err       <= w_req_err;
      r_rdata     <= '0;
      r_mem_wdata <= req_wdata;
    end else if (r_state == ST_READ) begin
      if (r_write) r_mem_wdata <= w_merged;
      else         r_rdata     <= w_load;
    end
  end

  assign resp_rdata     = r_rdata;
  assign resp_err       = r_err;
  assign mem_address    = r_word_idx;
  assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-level reference model.
module tb_load_store_unit;

  localparam int unsigned DEPTH = 256;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int unsigned cyc;
    int unsigned nrd;
    int unsigned nwr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  logic [63:0] mem     [DEPTH];
  logic [63:0] ref_mem [DEPTH];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [63:0] poke_val = '0;

  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write)    mem[mem_address[7:0]] <= mem_write_data;
    else if (poke_en) mem[poke_idx]         <= poke_val;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else             n_pass++;
  endtask

  task automatic poke(input int unsigned idx, input logic [63:0] val);
    @(negedge clk);
    poke_en  = 1'b1;
    poke_idx = idx[7:0];
    poke_val = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  // Reference model: byte-granular view of memory, updates ref_mem for stores
  task automatic model_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input int unsigned now, output exp_t e);
    int unsigned size, w, sh;
    logic [63:0] a, val, word;
    size  = 1 << f3[1:0];
    e.rdata = '0; e.nrd = 0; e.nwr = 0;
    e.err = (f3 == 3'b111) || (wr && f3[2]) || ((addr >> 3) >= 64'(DEPTH));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % 64'(size)) != 0) e.err = 1'b1;
`endif
    a = addr - (addr % 64'(size));
    if (e.err) begin
      e.cyc = now + 1;
    end else begin
      w    = 32'(a[10:3]);
      word = ref_mem[w];
      if (!wr) begin
        val = '0;
        for (int i = 0; i < int'(size); i++) begin
          sh  = 8 * (32'(a[2:0]) + i);
          val = val | (((word >> sh) & 64'hFF) << (8 * i));
        end
        if (!f3[2] && size < 8 && val[8*size-1]) val = val | (~64'd0 << (8 * size));
        e.rdata = val;
        e.cyc   = now + 2;
        e.nrd   = 1;
      end else begin
        for (int i = 0; i < int'(size); i++) begin
          sh   = 8 * (32'(a[2:0]) + i);
          word = (word & ~(64'hFF << sh)) | (((wd >> (8 * i)) & 64'hFF) << sh);
        end
        ref_mem[w] = word;
        e.cyc = now + ((size == 8) ? 2 : 3);
        e.nrd = (size == 8) ? 0 : 1;
        e.nwr = 1;
      end
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, output exp_t e);
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    model_req(wr, f3, addr, wd, cyc, e);
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("resp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  // Compare process: strobe rules every cycle, full response check on resp_valid
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_read || mem_write) begin
        chk("strobe_exclusive", 64'(mem_read && mem_write), 64'd0);
        chk("mem_addr_range", 64'(mem_address < 64'(DEPTH)), 64'd1);
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 64'(resp_err), 64'(e.err));
          chk("resp_latency", 64'(cyc), 64'(e.cyc));
          chk("mem_reads", 64'(rd_cnt), 64'(e.nrd));
          chk("mem_writes", 64'(wr_cnt), 64'(e.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    int unsigned bad;
    logic [63:0] a;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) poke(i, {$urandom, $urandom});

    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_address", mem_address, 64'd0);
    chk("rst_mem_wdata", mem_write_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    poke(2, 64'h1122334455667788);
    issue(1'b0, 3'b011, 64'h10, '0, e);
    chk("pin_ld_data", e.rdata, 64'h1122334455667788);

    poke(2, 64'h8011223344556677);
    issue(1'b0, 3'b000, 64'h17, '0, e);
    chk("pin_lb_data", e.rdata, 64'hFFFF_FFFF_FFFF_FF80);
    issue(1'b0, 3'b100, 64'h17, '0, e);
    chk("pin_lbu_data", e.rdata, 64'h80);

    poke(1, 64'd0);
    issue(1'b1, 3'b001, 64'h0A, 64'hABCD, e);
    chk("pin_sh_cycles", 64'(e.nrd + e.nwr), 64'd2);
    @(negedge clk);
    chk("sh_word1", mem[1], 64'h0000_0000_ABCD_0000);

    poke(0, 64'h0000_0000_8765_4321);
    issue(1'b0, 3'b010, 64'h02, '0, e);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("pin_lw_mis_err", 64'(e.err), 64'd1);
`else
    chk("pin_lw_mis_data", e.rdata, 64'hFFFF_FFFF_8765_4321);
`endif

    issue(1'b1, 3'b011, 64'h800, 64'hDEAD_BEEF_0000_0001, e);
    chk("pin_sd_oob_err", 64'(e.err), 64'd1);

    // Reset in WRITE of an SD: strobe drops at once, no response, word untouched
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011; req_addr = 64'h28;
    req_wdata = 64'h5555_AAAA_5555_AAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("sd_in_write", 64'(mem_write), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_word_kept", mem[5], ref_mem[5]);
    chk("rst_mid_no_resp", 64'(resp_valid), 64'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) a = {$urandom, $urandom};
      else                            a = 64'($urandom_range(0, 2047));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom}, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final_mismatch_words", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, the number of 64-bit words in the downstream data memory (power of two).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  a CPU request is present.
REQ-005 SHALL have port req_ready  output  1  the unit accepts a request this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV64 width/sign code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-008 SHALL have port req_addr  input  64  byte address.
REQ-009 SHALL have port req_wdata  input  64  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  64  load result, sign/zero-extended; 0 for stores.
REQ-012 SHALL have port resp_err  output  1  request rejected; valid with resp_valid.
REQ-013 SHALL have ports mem_read, mem_write (output 1), mem_address (output 64, word index), mem_write_data (output 64), mem_read_data (input 64, combinational read).

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL capture addr, funct3, write, wdata on req_valid & req_ready.
REQ-016 SHALL drive mem_address = captured addr >> 3; memory lanes little-endian; byte offset = addr[2:0].
REQ-017 Load: IDLE -> READ (mem_read=1, extract/extend lane into a register) -> RESP; resp_valid 2 cycles after accept.
REQ-018 Doubleword store: IDLE -> WRITE (mem_write=1, data = wdata) -> RESP; resp_valid 2 cycles after accept.
REQ-019 Byte/half/word store: IDLE -> READ (capture word) -> WRITE (merge only the addressed bytes) -> RESP; resp_valid 3 cycles after accept.
REQ-020 RESP SHALL last exactly one cycle and then return to IDLE; no back-pressure on the response.
REQ-021 Errors: funct3 111, store funct3 ≥ 100, or word index ≥ MEM_DEPTH SHALL go IDLE -> RESP with resp_err=1 and no memory access.
REQ-022 mem_read and mem_write SHALL never be asserted together, and never outside READ/WRITE.
REQ-023 Requests presented while req_ready=0 SHALL be ignored; the requester holds them.

Reset
REQ-024 On rst_n low, asynchronously: state IDLE; req_ready=1; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_address, mem_write_data = 0.
REQ-025 Reset during READ/WRITE SHALL suppress the memory strobe immediately and discard the request; no response issued.

Configuration
REQ-026 Macro LSU_MISALIGN_TRAP_EN: when defined, an access not naturally aligned SHALL be rejected per REQ-021 with resp_err=1.
REQ-027 Without LSU_MISALIGN_TRAP_EN: low address bits below natural alignment SHALL be forced to zero and the access completes normally.

Structure
REQ-028 A shared package SHALL hold the funct3 width codes, the FSM state encoding and the XLEN=64 constant.
REQ-029 Lane extract/extend and byte-merge logic SHALL form one combinational sub-module, lsu_lane_align.

Verification
REQ-030 LD at 0x10, memory word 2 = 0x1122334455667788 -> resp_rdata 0x1122334455667788, resp_valid at accept+2.
REQ-031 LB at 0x17, word 2 = 0x80xxxxxxxxxxxxxx -> resp_rdata 0xFFFFFFFFFFFFFF80; LBU at the same address -> 0x80.
REQ-032 SH wdata 0xABCD at 0x0A, word 1 = 0 -> word 1 = 0x00000000ABCD0000, one READ and one WRITE, resp_valid at accept+3.
REQ-033 LW at 0x02 -> with macro: resp_err=1, no mem strobes; without macro: LW from 0x00.
REQ-034 Store to 0x800 (index 256) with MEM_DEPTH 256 -> resp_err=1, memory unchanged.
REQ-035 rst_n low in WRITE of an SD -> mem_write drops at once, FSM in IDLE, no resp_valid, target word unchanged.
